// File: rtl/lenet_pkg.sv
// ============================================================================
//  Module      : lenet_pkg
//  Description : Shared LeNet constants and the argmax classifier state type.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package lenet_pkg;

    localparam int LENET_BITWIDTH    = 16;
    localparam int LENET_NUM_CLASSES = 10;
    localparam int LENET_IDX_W       = 4;

    typedef enum logic [1:0] {
        ARGMAX_IDLE = 2'd0,
        ARGMAX_SCAN = 2'd1,
        ARGMAX_DONE = 2'd2
    } argmax_state_t;

endpackage

`default_nettype wire

// File: rtl/classifier_argmax_3.sv
// ============================================================================
//  Module      : classifier_argmax_3
//  Description : Sequential argmax over the final-layer class scores using a
//                single reused signed comparator (one element per cycle).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module classifier_argmax_3
    import lenet_pkg::*;
#(
    parameter int bitwidth    = LENET_BITWIDTH,
    parameter int NUM_CLASSES = LENET_NUM_CLASSES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [bitwidth-1:0]        featuremap [NUM_CLASSES-1:0],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic        [LENET_IDX_W-1:0]     class_idx,
    output logic signed [bitwidth-1:0]        class_score
);

    localparam logic [LENET_IDX_W-1:0] c_last_idx = LENET_IDX_W'(NUM_CLASSES - 1);

    argmax_state_t                     r_state;
    logic signed [bitwidth-1:0]        r_vec [NUM_CLASSES-1:0];
    logic        [LENET_IDX_W-1:0]     r_cnt;
    logic signed [bitwidth-1:0]        r_best_score;
    logic        [LENET_IDX_W-1:0]     r_best_idx;
    logic                              r_out_valid;
    logic        [LENET_IDX_W-1:0]     r_class_idx;
    logic signed [bitwidth-1:0]        r_class_score;

    logic signed [bitwidth-1:0]        w_cand;
    logic                              w_gt;

    // Strictly-greater keeps the lowest index on ties.
    assign w_cand = r_vec[r_cnt];
    assign w_gt   = (w_cand > r_best_score);

    assign in_ready    = (r_state == ARGMAX_IDLE);
    assign out_valid   = r_out_valid;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARGMAX_IDLE;
            r_cnt         <= '0;
            r_best_score  <= '0;
            r_best_idx    <= '0;
            r_out_valid   <= 1'b0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_vec[i] <= '0;
            end
        end else begin
            case (r_state)
                ARGMAX_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            r_vec[i] <= featuremap[i];
                        end
                        r_best_score <= featuremap[0];
                        r_best_idx   <= '0;
                        r_cnt        <= LENET_IDX_W'(1);
                        r_state      <= ARGMAX_SCAN;
                    end
                end
                ARGMAX_SCAN: begin
                    if (w_gt) begin
                        r_best_score <= w_cand;
                        r_best_idx   <= r_cnt;
                    end
                    if (r_cnt == c_last_idx) begin
                        // Publish including the final compare, which has not yet landed in r_best_*.
                        r_class_idx   <= w_gt ? r_cnt  : r_best_idx;
                        r_class_score <= w_gt ? w_cand : r_best_score;
                        r_out_valid   <= 1'b1;
                        r_state       <= ARGMAX_DONE;
                    end else begin
                        r_cnt <= r_cnt + LENET_IDX_W'(1);
                    end
                end
                ARGMAX_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ARGMAX_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ARGMAX_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_classifier_argmax_3.sv
// ============================================================================
//  Module      : tb_classifier_argmax_3
//  Description : Self-checking bench for classifier_argmax_3.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_classifier_argmax_3;

    localparam int NC = 10;
    localparam int BW = 16;

    typedef logic signed [BW-1:0] fm_t [NC-1:0];

    typedef struct {
        fm_t fm;
        int  idx;
        int  score;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] featuremap [NC-1:0];
    logic                 out_valid;
    logic                 out_ready;
    logic        [3:0]    class_idx;
    logic signed [BW-1:0] class_score;

    int n_vec  = 0;
    int n_fail = 0;

    classifier_argmax_3 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .featuremap  (featuremap),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: first index holding the largest signed value.
    task automatic ref_argmax(input fm_t fm, output int idx, output int score);
        idx   = 0;
        score = int'(fm[0]);
        for (int i = 1; i < NC; i++) begin
            if (int'(fm[i]) > score) begin
                idx   = i;
                score = int'(fm[i]);
            end
        end
    endtask

    task automatic set_fm(input fm_t fm);
        for (int i = 0; i < NC; i++) featuremap[i] = fm[i];
    endtask

    task automatic scramble_fm();
        for (int i = 0; i < NC; i++) featuremap[i] = BW'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input fm_t fm);
        int w;
        set_fm(fm);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        scramble_fm();
    endtask

    task automatic expect_result(input fm_t fm, input int exp_idx, input int exp_score, input string tag);
        int lat;
        int r_idx, r_score;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        ref_argmax(fm, r_idx, r_score);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_ref_idx"}, int'(class_idx), r_idx);
        check({tag, "_ref_score"}, int'(class_score), r_score);
        if (exp_idx >= 0) begin
            check({tag, "_tbl_idx"}, int'(class_idx), exp_idx);
            check({tag, "_tbl_score"}, int'(class_score), exp_score);
        end
        check({tag, "_in_ready_done"}, int'(in_ready), 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, int'(out_valid), 0);
        check({tag, "_hs_in_ready"}, int'(in_ready), 1);
    endtask

    function automatic fm_t zero_fm();
        fm_t f;
        for (int i = 0; i < NC; i++) f[i] = '0;
        return f;
    endfunction

    vec_t tbl [6];
    fm_t  v, v2;
    fm_t  bb [3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        featuremap = zero_fm();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_idx", int'(class_idx), 0);
        check("rst_score", int'(class_score), 0);

        // Directed table.
        tbl[0].fm = zero_fm(); tbl[0].fm[1] = 16'sd5; tbl[0].fm[2] = 16'sd3;
        tbl[0].fm[5] = 16'sd4; tbl[0].idx = 1; tbl[0].score = 5;
        tbl[1].fm = zero_fm(); tbl[1].fm[3] = 16'sd100; tbl[1].fm[7] = 16'sd100;
        tbl[1].idx = 3; tbl[1].score = 100;
        tbl[2].fm = zero_fm(); tbl[2].idx = 0; tbl[2].score = 0;
        for (int i = 0; i < NC; i++) tbl[3].fm[i] = -16'sd1;
        tbl[3].fm[9] = -16'sd2; tbl[3].idx = 0; tbl[3].score = -1;
        for (int i = 0; i < NC; i++) tbl[4].fm[i] = -16'sd32768;
        tbl[4].idx = 0; tbl[4].score = -32768;
        for (int i = 0; i < NC; i++) tbl[5].fm[i] = 16'(i * 7 - 40);
        tbl[5].idx = 9; tbl[5].score = 23;

        for (int k = 0; k < 6; k++) begin
            accept(tbl[k].fm);
            expect_result(tbl[k].fm, tbl[k].idx, tbl[k].score, $sformatf("tbl%0d", k));
            handshake($sformatf("tbl%0d", k));
        end

        // Randomized vectors, half drawn from a tiny range to provoke ties.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < NC; i++) begin
                if (k % 2 == 0) v[i] = BW'($urandom);
                else            v[i] = BW'(int'($urandom_range(0, 6)) - 3);
            end
            accept(v);
            expect_result(v, -1, 0, $sformatf("rnd%0d", k));
            handshake($sformatf("rnd%0d", k));
        end

        // Backpressure in DONE with a pending new vector on the input.
        v = zero_fm(); v[4] = 16'sd77; v[6] = -16'sd900;
        v2 = zero_fm(); v2[8] = 16'sd1234;
        accept(v);
        expect_result(v, 4, 77, "bp");
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            featuremap[c] = 16'sd30000;
            tick();
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_idx", int'(class_idx), 4);
            check("bp_hold_score", int'(class_score), 77);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        set_fm(v2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_idle_out_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        scramble_fm();
        check("bp_accepted", int'(in_ready), 0);
        expect_result(v2, 8, 1234, "bp2");
        handshake("bp2");

        // Reset during SCAN abandons the vector; in_valid during reset is ignored.
        v = zero_fm(); v[2] = 16'sd55;
        accept(v);
        repeat (3) begin
            tick();
            check("rs_no_valid", int'(out_valid), 0);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        set_fm(v);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rs_in_ready", int'(in_ready), 1);
        check("rs_out_valid", int'(out_valid), 0);
        check("rs_idx", int'(class_idx), 0);
        check("rs_score", int'(class_score), 0);
        begin
            int seen = 0;
            repeat (12) begin
                tick();
                if (out_valid) seen++;
            end
            check("rs_no_pulse", seen, 0);
        end
        v = zero_fm(); v[0] = 16'sd100; v[9] = 16'sh7FFF;
        accept(v);
        expect_result(v, 9, 32767, "rs_fresh");
        handshake("rs_fresh");

        // Back-to-back with in_valid and out_ready held high.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NC; i++) bb[k][i] = BW'($urandom);
        begin
            int cyc = 0, prev = -1, k_in = 0, k_out = 0;
            int r_idx, r_score;
            bit acc, ho;
            set_fm(bb[0]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (k_out < 3 && cyc < 100) begin
                acc = in_ready && in_valid;
                ho  = out_valid;
                if (ho) begin
                    ref_argmax(bb[k_out], r_idx, r_score);
                    check("b2b_idx", int'(class_idx), r_idx);
                    check("b2b_score", int'(class_score), r_score);
                    k_out++;
                end
                tick();
                cyc++;
                if (acc) begin
                    if (k_in > 0) check("b2b_spacing", cyc - prev, 11);
                    prev = cyc;
                    k_in++;
                    if (k_in < 3) set_fm(bb[k_in]);
                    else begin
                        in_valid = 1'b0;
                        scramble_fm();
                    end
                end
            end
            check("b2b_results", k_out, 3);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/classifier_argmax_3.md
CLASSIFIER_ARGMAX_3 -- requirements
Module: classifier_argmax_3

Interface
REQ-001 SHALL have parameter bitwidth, default 16, giving the element width of the two's-complement signed score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, giving the number of class scores per vector; index width is 4 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the featuremap vector is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 SHALL have port featuremap, input, signed [bitwidth-1:0] x NUM_CLASSES (unpacked [9:0]): the layer-3 activations after ReLU.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-010 SHALL have port class_idx, output, [3:0]: the index of the maximum score.
REQ-011 SHALL have port class_score, output, signed [bitwidth-1:0]: the maximum score value.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid 0; every other state drives in_ready 0.
REQ-014 On an edge with in_valid && in_ready, the block SHALL:
- register all NUM_CLASSES elements into an internal vector;
- load best_score = featuremap[0], best_idx = 0, scan counter = 1;
- go to SCAN.
REQ-015 In SCAN, each cycle SHALL compare one element vec[counter] against best_score, signed, and increment the counter.
REQ-016 The update SHALL occur only if vec[counter] > best_score, strictly; ties therefore keep the lowest index.
REQ-017 After the compare of index NUM_CLASSES-1, the FSM SHALL go to DONE; the counter never wraps past NUM_CLASSES-1.
REQ-018 Latency: out_valid SHALL rise exactly NUM_CLASSES-1 (9) cycles after the accept edge.
REQ-019 In DONE, out_valid SHALL be 1, and class_idx/class_score SHALL hold stable until the out_valid && out_ready edge.
REQ-020 The out_valid && out_ready edge SHALL move the FSM to IDLE; in_ready is 1 in the following cycle.
REQ-021 Input and output SHALL NOT overlap; peak throughput is one vector per NUM_CLASSES+1 cycles.
REQ-022 Changes on featuremap after the accept edge SHALL NOT affect the result.
REQ-023 Negative inputs, i.e. not ReLU'd, SHALL be compared correctly as signed values.
REQ-024 When out_valid is 0, class_idx/class_score SHALL retain their last values (no X).

Reset
REQ-025 While rst is 1 at an edge, the block SHALL set:
- FSM = IDLE;
- out_valid = 0;
- class_idx = 0, class_score = 0;
- counter = 0, internal vector = 0.
REQ-026 Reset mid-SCAN or in DONE SHALL abandon the vector without emitting a result; the first post-reset cycle has in_ready = 1.
REQ-027 in_valid SHALL be ignored on any edge where rst is 1.

Structure
REQ-028 Package lenet_pkg SHALL hold bitwidth, NUM_CLASSES, the index width and the argmax state enum, shared with the other layers.
REQ-029 The block SHALL be a single module with no sub-module; the compare is one signed comparator reused across SCAN cycles.

Verification
REQ-030 Scenario 1: vector {0,5,3,...,0} with element 1 = 5, others < 5, out_ready=1 -> class_idx=1, class_score=5, out_valid at accept+9.
REQ-031 Scenario 2: elements 3 and 7 both 100, others 0 -> class_idx=3 (lowest-index tie rule).
REQ-032 Scenario 3: all-zero vector -> class_idx=0, class_score=0; all elements -1 except element 9 = -2 -> class_idx=0, class_score=-1.
REQ-033 Scenario 4: out_ready held 0 for 5 cycles in DONE, with featuremap changed and in_valid=1 meanwhile -> outputs stable and in_ready=0 until handshake; the next vector is accepted only after IDLE.
REQ-034 Scenario 5: rst pulsed at scan cycle 4 -> no out_valid pulse; a fresh vector with max 0x7FFF at index 9 -> class_idx=9, class_score=32767.
REQ-035 Scenario 6: back-to-back vectors with in_valid and out_ready held 1 -> accepts spaced exactly 11 cycles apart, each result correct.
